// File: rtl/universal_shift_register.sv
`default_nettype none
// universal_shift_register: WIDTH-bit register with clear/load, six shift/rotate
// modes and an MSB-first serialise burst with busy/done handshake.  Rev 1.0
module universal_shift_register #(
  parameter int unsigned      WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             Clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] D,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic             sin_lsb,
  input  logic             sin_msb,
  input  logic             start,
  output logic [WIDTH-1:0] Q,
  output logic             so_msb,
  output logic             so_lsb,
  output logic             busy,
  output logic             done
);

  localparam int unsigned      CNT_W    = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH);

  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_SHL  = 3'b001;
  localparam logic [2:0] MODE_SHR  = 3'b010;
  localparam logic [2:0] MODE_ROL  = 3'b011;
  localparam logic [2:0] MODE_ROR  = 3'b100;
  localparam logic [2:0] MODE_ASR  = 3'b101;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] mode_val;
  logic [WIDTH-1:0] burst_val;
  logic [CNT_W-1:0] cnt_inc;

  assign burst_val = {q_q[WIDTH-2:0], sin_lsb};
  assign cnt_inc   = cnt_q + CNT_W'(1);

  always_comb begin : mode_mux
    mode_val = q_q;
    case (mode)
      MODE_HOLD: mode_val = q_q;
      MODE_SHL:  mode_val = {q_q[WIDTH-2:0], sin_lsb};
      MODE_SHR:  mode_val = {sin_msb, q_q[WIDTH-1:1]};
      MODE_ROL:  mode_val = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
      MODE_ROR:  mode_val = {q_q[0], q_q[WIDTH-1:1]};
      MODE_ASR:  mode_val = {q_q[WIDTH-1], q_q[WIDTH-1:1]};
      default:   mode_val = q_q;
    endcase
  end

  // Clear beats everything in both states; in SHIFT it aborts without a done pulse.
  always_comb begin : next_state
    state_d = state_q;
    q_d     = q_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (clear) begin
          q_d = '0;
        end else if (load) begin
          q_d = D;
        end else if (start) begin
          state_d = ST_SHIFT;
          cnt_d   = '0;
          busy_d  = 1'b1;
        end else if (en) begin
          q_d = mode_val;
        end
      end
      ST_SHIFT: begin
        if (clear) begin
          q_d     = '0;
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end else begin
          q_d   = burst_val;
          cnt_d = cnt_inc;
          if (cnt_inc == CNT_LAST) begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      q_q     <= RESET_VALUE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign Q      = q_q;
  assign so_msb = q_q[WIDTH-1];
  assign so_lsb = q_q[0];
  assign busy   = busy_q;
  assign done   = done_q;

endmodule
`default_nettype wire

// File: tb/tb_universal_shift_register.sv
`default_nettype none
// tb_universal_shift_register: directed stimulus for the 8-bit register against a
// behavioural model, plus burst-length sweeps on 2-bit and 32-bit instances.
module tb_universal_shift_register;

  localparam int         W  = 8;
  localparam logic [7:0] RV = 8'hA5;

  logic         Clk = 1'b0;
  logic         reset_n, clear, load, en, start, sin_lsb, sin_msb;
  logic [2:0]   mode;
  logic [W-1:0] D;
  logic [W-1:0] Q;
  logic         so_msb, so_lsb, busy, done;

  logic         start2, start32;
  logic [1:0]   Q2;
  logic [31:0]  Q32;
  logic         so_msb2, so_lsb2, busy2, done2;
  logic         so_msb32, so_lsb32, busy32, done32;

  int checks   = 0;
  int failures = 0;

  always #5 Clk = ~Clk;

  universal_shift_register #(.WIDTH(8), .RESET_VALUE(RV)) u_dut8 (
    .Clk(Clk), .reset_n(reset_n), .clear(clear), .load(load), .D(D), .en(en),
    .mode(mode), .sin_lsb(sin_lsb), .sin_msb(sin_msb), .start(start),
    .Q(Q), .so_msb(so_msb), .so_lsb(so_lsb), .busy(busy), .done(done)
  );

  universal_shift_register #(.WIDTH(2), .RESET_VALUE(2'b01)) u_dut2 (
    .Clk(Clk), .reset_n(reset_n), .clear(clear), .load(load), .D(2'b10), .en(en),
    .mode(mode), .sin_lsb(sin_lsb), .sin_msb(sin_msb), .start(start2),
    .Q(Q2), .so_msb(so_msb2), .so_lsb(so_lsb2), .busy(busy2), .done(done2)
  );

  universal_shift_register #(.WIDTH(32), .RESET_VALUE(32'h0)) u_dut32 (
    .Clk(Clk), .reset_n(reset_n), .clear(clear), .load(load), .D(32'hDEADBEEF), .en(en),
    .mode(mode), .sin_lsb(sin_lsb), .sin_msb(sin_msb), .start(start32),
    .Q(Q32), .so_msb(so_msb32), .so_lsb(so_lsb32), .busy(busy32), .done(done32)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Behavioural model: register value as an integer, burst as a count of bits left.
  logic [W-1:0] m_q;
  int           m_left = 0;
  logic         m_done = 1'b0;

  function automatic int mode_next(input int v, input logic [2:0] md, input int sl, input int sm);
    int top;
    int full;
    top  = 1 << (W - 1);
    full = 1 << W;
    case (md)
      3'd1:    return (v * 2 + sl) % full;
      3'd2:    return v / 2 + sm * top;
      3'd3:    return (v * 2) % full + v / top;
      3'd4:    return v / 2 + (v % 2) * top;
      3'd5:    return v / 2 + (v / top) * top;
      default: return v;
    endcase
  endfunction

  always @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      m_q    <= RV;
      m_left <= 0;
      m_done <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (clear) begin
        m_q    <= '0;
        m_left <= 0;
      end else if (m_left != 0) begin
        m_q    <= W'((int'(m_q) * 2 + int'(sin_lsb)) % (1 << W));
        m_left <= m_left - 1;
        if (m_left == 1) m_done <= 1'b1;
      end else if (load) begin
        m_q <= D;
      end else if (start) begin
        m_left <= W;
      end else if (en) begin
        m_q <= W'(mode_next(int'(m_q), mode, int'(sin_lsb), int'(sin_msb)));
      end
    end
  end

  initial begin
    @(posedge Clk);
    forever begin
      @(negedge Clk);
      chk("model_q", 32'(Q), 32'(m_q));
      chk("model_busy", 32'(busy), 32'(m_left != 0));
      chk("model_done", 32'(done), 32'(m_done));
      chk("model_so_msb", 32'(so_msb), 32'(m_q[W-1]));
      chk("model_so_lsb", 32'(so_lsb), 32'(m_q[0]));
    end
  end

  task automatic tick();
    @(negedge Clk);
  endtask

  task automatic load_val(input logic [W-1:0] v);
    load = 1'b1;
    D    = v;
    tick();
    load = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 40) begin
      tick();
      n++;
    end
  endtask

  typedef struct {
    logic [2:0] md;
    logic       e;
    logic [7:0] exp;
  } mode_vec_t;

  mode_vec_t mvec[7];

  initial begin
    int n;
    int nb;
    int ndone;
    logic [7:0] bits;

    mvec[0] = '{3'b001, 1'b1, 8'h2D};
    mvec[1] = '{3'b010, 1'b1, 8'h4B};
    mvec[2] = '{3'b011, 1'b1, 8'h2D};
    mvec[3] = '{3'b100, 1'b1, 8'h4B};
    mvec[4] = '{3'b101, 1'b1, 8'hCB};
    mvec[5] = '{3'b110, 1'b1, 8'h96};
    mvec[6] = '{3'b001, 1'b0, 8'h96};

    reset_n = 1'b0; clear = 1'b0; load = 1'b0; en = 1'b0; start = 1'b0;
    start2 = 1'b0; start32 = 1'b0; mode = 3'b000; sin_lsb = 1'b0; sin_msb = 1'b0;
    D = '0;
    repeat (2) tick();
    chk("rst_q", 32'(Q), 32'hA5);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_q2", 32'(Q2), 32'h1);

    reset_n = 1'b1;
    tick();
    chk("rst_release_q", 32'(Q), 32'hA5);

    load_val(8'h3C);
    chk("load_q", 32'(Q), 32'h3C);

    clear = 1'b1; load = 1'b1; D = 8'hFF;
    tick();
    clear = 1'b0; load = 1'b0;
    chk("clear_over_load_q", 32'(Q), 32'h00);

    for (int i = 0; i < 7; i++) begin
      load_val(8'h96);
      en = mvec[i].e; mode = mvec[i].md; sin_lsb = 1'b1; sin_msb = 1'b0;
      tick();
      en = 1'b0; mode = 3'b000; sin_lsb = 1'b0;
      chk($sformatf("mode%0d_q", i), 32'(Q), 32'(mvec[i].exp));
      chk($sformatf("mode%0d_model_pin", i), 32'(m_q), 32'(mvec[i].exp));
    end

    // Serialise C3 MSB first.
    load_val(8'hC3);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("burst_busy_start", 32'(busy), 32'h1);
    chk("burst_q_start", 32'(Q), 32'hC3);
    bits = 8'hC3; nb = 0; ndone = 0;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("burst_so_msb%0d", i), 32'(so_msb), 32'(bits[7-i]));
      if (busy) nb++;
      if (done) ndone++;
      tick();
    end
    chk("burst_busy_cycles", 32'(nb), 32'd8);
    chk("burst_no_early_done", 32'(ndone), 32'd0);
    chk("burst_done", 32'(done), 32'h1);
    chk("burst_busy_end", 32'(busy), 32'h0);
    chk("burst_q_end", 32'(Q), 32'h00);
    tick();
    chk("burst_done_one_cycle", 32'(done), 32'h0);

    // Controls applied mid-burst must be ignored.
    load_val(8'hC3);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    load = 1'b1; D = 8'hFF; en = 1'b1; mode = 3'b100; start = 1'b1;
    tick();
    load = 1'b0; en = 1'b0; mode = 3'b000; start = 1'b0;
    wait_done(n);
    chk("ignore_burst_len", 32'(3 + n), 32'd8);
    chk("ignore_q_end", 32'(Q), 32'h00);
    tick();

    // Clear on the 4th burst edge aborts with no done.
    load_val(8'hC3);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("abort_clear_q", 32'(Q), 32'h00);
    chk("abort_clear_busy", 32'(busy), 32'h0);
    ndone = 0;
    repeat (10) begin
      if (done) ndone++;
      tick();
    end
    chk("abort_clear_no_done", 32'(ndone), 32'd0);

    // Asynchronous reset mid-burst, checked between clock edges.
    load_val(8'hC3);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    #2 reset_n = 1'b0;
    #1;
    chk("abort_rst_q", 32'(Q), 32'hA5);
    chk("abort_rst_busy", 32'(busy), 32'h0);
    chk("abort_rst_done", 32'(done), 32'h0);
    tick();
    reset_n = 1'b1;
    tick();
    chk("abort_rst_after_q", 32'(Q), 32'hA5);
    chk("abort_rst_after_done", 32'(done), 32'h0);

    // Back-to-back bursts: second start sampled on the done cycle.
    load_val(8'hC3);
    sin_lsb = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(n);
    chk("b2b_first_len", 32'(n), 32'd8);
    chk("b2b_first_done", 32'(done), 32'h1);
    start = 1'b1; sin_lsb = 1'b1;
    tick();
    start = 1'b0;
    chk("b2b_second_busy", 32'(busy), 32'h1);
    chk("b2b_second_done_low", 32'(done), 32'h0);
    wait_done(n);
    chk("b2b_second_len", 32'(n), 32'd8);
    chk("b2b_second_q", 32'(Q), 32'hFF);
    sin_lsb = 1'b0;
    tick();

    // Width sweep.
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    n = 0;
    while (busy2 && n < 100) begin
      n++;
      tick();
    end
    chk("w2_busy_cycles", 32'(n), 32'd2);
    chk("w2_done", 32'(done2), 32'h1);

    start32 = 1'b1;
    tick();
    start32 = 1'b0;
    n = 0;
    while (busy32 && n < 100) begin
      n++;
      tick();
    end
    chk("w32_busy_cycles", 32'(n), 32'd32);
    chk("w32_done", 32'(done32), 32'h1);

    repeat (2) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/universal_shift_register.md
# universal_shift_register

Parametrised universal shift register: WIDTH-bit storage with synchronous clear, parallel load, six shift/rotate modes and an automatic MSB-first serialise burst with busy/done handshake. Successor to the fixed 4-bit load/reset register in the shift-register labs. Used as the general-purpose datapath register and as a parallel-to-serial converter feeding serial links.

## Interface
- WIDTH, 8, register width in bits; legal range 2..32.
- RESET_VALUE, 0, value of Q after asynchronous reset; WIDTH bits.
- Clk  in  1  rising-edge clock; single clock domain.
- reset_n  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous clear of Q to 0.
- load  in  1  synchronous parallel load of D.
- D  in  WIDTH  parallel load data.
- en  in  1  shift enable for the mode operation.
- mode  in  3  000 hold, 001 SHL, 010 SHR, 011 ROL, 100 ROR, 101 ASR; 110/111 hold.
- sin_lsb  in  1  serial input to bit 0 on SHL and during bursts.
- sin_msb  in  1  serial input to bit WIDTH-1 on SHR.
- start  in  1  begin a WIDTH-cycle serialise burst.
- Q  out  WIDTH  register contents.
- so_msb  out  1  Q[WIDTH-1], combinational from Q.
- so_lsb  out  1  Q[0], combinational from Q.
- busy  out  1  high while a burst is in progress.
- done  out  1  one-cycle pulse at burst completion.

## Operation
- States: IDLE, SHIFT. Internal counter cnt of width clog2(WIDTH+1).
- reset_n low: Q=RESET_VALUE, state=IDLE, cnt=0, busy=0, done=0, immediately and independent of Clk.
- IDLE priority, highest first at each edge: clear (Q=0), load (Q=D), start (state->SHIFT, cnt=0, busy=1, Q unchanged), en with mode, otherwise hold.
- Mode operations when en=1 in IDLE:
  - SHL: Q={Q[WIDTH-2:0],sin_lsb}.
  - SHR: Q={sin_msb,Q[WIDTH-1:1]}.
  - ROL: Q={Q[WIDTH-2:0],Q[WIDTH-1]}.
  - ROR: Q={Q[0],Q[WIDTH-1:1]}.
  - ASR: Q={Q[WIDTH-1],Q[WIDTH-1:1]}.
  - Undefined codes hold.
- en=0 holds regardless of mode.
- SHIFT state: each edge performs SHL with sin_lsb and increments cnt. On the edge where cnt reaches WIDTH, state->IDLE, busy=0, done=1.
- During SHIFT, load, start, en and mode are ignored. clear aborts the burst: Q=0, state=IDLE, busy=0, done stays 0.
- done is 0 on every edge other than the completion edge.

## Timing
- All outputs other than so_msb/so_lsb are registered; Q changes only at Clk rising edges or on reset_n assertion.
- load/clear/shift latency: 1 edge.
- Burst: start sampled at edge k gives busy=1 from edge k. Shifts occur at edges k+1..k+WIDTH. At edge k+WIDTH, busy=0 and done=1 for exactly one cycle.
- A consumer sampling so_msb at edges k+1..k+WIDTH receives the bits of Q captured at edge k, MSB first.
- A start asserted in the same cycle as done (state IDLE) is accepted, giving back-to-back bursts with no gap cycle beyond the start edge.
- A reset_n assertion mid-burst terminates it immediately; no done pulse is produced.

## Test plan
- Reset and load, WIDTH=8, RESET_VALUE=8'hA5: deassert reset_n -> Q=A5, busy=0, done=0. Then load=1, D=3C for one edge -> Q=3C. Then clear and load together -> Q=00.
- Modes from Q=8'b1001_0110 with en=1, sin_lsb=1, sin_msb=0, one edge each: SHL -> 2D, SHR -> 4B, ROL -> 2D, ROR -> 4B, ASR -> CB. Mode 110 -> 96. en=0 with SHL -> 96.
- Burst: load C3, start for one cycle, sin_lsb=0 -> so_msb sampled over edges 1..8 = 1,1,0,0,0,0,1,1. busy is high for 8 cycles after the start edge, done pulses once, final Q=00.
- Ignore during burst: mid-burst apply load=1, D=FF, en=1, mode=ROR and start=1 -> no effect, burst completes normally at the same cycle count.
- Abort: clear at the 4th burst edge -> Q=00, busy=0, no done pulse. Repeat with reset_n low mid-burst -> Q=RESET_VALUE asynchronously, busy=0.
- Back-to-back and width sweep: start asserted on the done cycle -> second burst begins without an idle cycle. Run WIDTH=2 and WIDTH=32 -> busy lasts exactly WIDTH cycles in each case.
